// File: rtl/tile_rule_engine.sv
// Trax legal-move evaluator for one cell: tests the six tile orientations against neighbour edge colours.
// Latency 6/CAND_PER_CYCLE cycles from accept to out_valid; result held while out_ready is low, no new request until drained.
module tile_rule_engine #(
  parameter int CAND_PER_CYCLE = 1,
  parameter bit STRICT         = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] up_tile,
  input  logic [2:0] down_tile,
  input  logic [2:0] left_tile,
  input  logic [2:0] right_tile,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] tile_type,
  output logic [2:0] legal_count,
  output logic       forced,
  output logic       illegal,
  output logic       isolated,
  output logic       bad_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (!(CAND_PER_CYCLE == 1 || CAND_PER_CYCLE == 2 || CAND_PER_CYCLE == 3 || CAND_PER_CYCLE == 6)) begin : g_bad_cfg
      $error("tile_rule_engine: CAND_PER_CYCLE must be 1, 2, 3 or 6");
    end
  endgenerate

  logic [1:0] state;
  logic [2:0] up_q, down_q, left_q, right_q;
  logic [5:0] acc;
  logic [2:0] k;

  // White edges packed as {D,R,U,L}; empty and reserved codes have none.
  function automatic logic [3:0] white_edges(input logic [2:0] code);
    case (code)
      3'd1:    white_edges = 4'b0011;
      3'd2:    white_edges = 4'b1100;
      3'd3:    white_edges = 4'b0110;
      3'd4:    white_edges = 4'b1001;
      3'd5:    white_edges = 4'b0101;
      3'd6:    white_edges = 4'b1010;
      default: white_edges = 4'b0000;
    endcase
  endfunction

  function automatic logic edge_white(input logic [2:0] code, input logic [1:0] side);
    logic [3:0] w;
    w = white_edges(code);
    return w[side];
  endfunction

  // Colour each of our edges must take, taken from the neighbour's facing edge.
  logic [3:0] need, active;
  assign need   = {edge_white(down_q, 2'd1), edge_white(right_q, 2'd0),
                   edge_white(up_q, 2'd3),   edge_white(left_q, 2'd2)};
  assign active = {down_q != 3'd0, right_q != 3'd0, up_q != 3'd0, left_q != 3'd0};

  logic [5:0] hits;
  always_comb begin
    hits = '0;
    for (int j = 0; j < CAND_PER_CYCLE; j++) begin
      if (((white_edges(3'(int'(k) + j)) ^ need) & active) == 4'b0000)
        hits[3'(int'(k) + j - 1)] = 1'b1;
    end
  end

  logic last_step;
  assign last_step = (int'(k) + CAND_PER_CYCLE) > 6;

  logic any_bad, no_nbr;
  assign any_bad = (up_q == 3'd7) || (down_q == 3'd7) || (left_q == 3'd7) || (right_q == 3'd7);
  assign no_nbr  = (active == 4'b0000);

  logic [5:0] res_mask;
  logic [2:0] res_cnt;
  logic       res_forced, res_illegal;
  always_comb begin
    res_mask    = acc | hits;
    res_cnt     = 3'($countones(acc | hits));
    res_forced  = 1'b0;
    res_illegal = 1'b0;
    if (any_bad) begin
      res_mask = '0;
      res_cnt  = '0;
    end else if (no_nbr) begin
      res_mask = STRICT ? 6'b000000 : 6'b111111;
      res_cnt  = STRICT ? 3'd0 : 3'd6;
    end else begin
      res_forced  = (res_cnt == 3'd1);
      res_illegal = (res_cnt == 3'd0);
    end
  end

  assign in_ready = (state == S_IDLE) && reset_n;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      up_q        <= '0;
      down_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      acc         <= '0;
      k           <= 3'd1;
      out_valid   <= 1'b0;
      tile_type   <= '0;
      legal_count <= '0;
      forced      <= 1'b0;
      illegal     <= 1'b0;
      isolated    <= 1'b0;
      bad_code    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            up_q    <= up_tile;
            down_q  <= down_tile;
            left_q  <= left_tile;
            right_q <= right_tile;
            acc     <= '0;
            k       <= 3'd1;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          acc <= acc | hits;
          k   <= k + 3'(CAND_PER_CYCLE);
          if (last_step) begin
            state       <= S_DONE;
            out_valid   <= 1'b1;
            tile_type   <= res_mask;
            legal_count <= res_cnt;
            forced      <= res_forced;
            illegal     <= res_illegal;
            isolated    <= no_nbr;
            bad_code    <= any_bad;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_rule_engine.sv
// Bench for tile_rule_engine: five instances (CAND_PER_CYCLE 1/2/3/6 strict, 1 non-strict) share stimulus.
// Expected results are queued at request time and popped when the instances report.
module tb_tile_rule_engine;

  localparam int N = 5;

  function automatic int cpc_of(input int i);
    case (i)
      1:       return 2;
      2:       return 3;
      3:       return 6;
      default: return 1;
    endcase
  endfunction

  function automatic bit str_of(input int i);
    return i != 4;
  endfunction

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] up_tile = 3'd0, down_tile = 3'd0, left_tile = 3'd0, right_tile = 3'd0;

  logic       ir [N];
  logic       ov [N];
  logic [5:0] tt [N];
  logic [2:0] lc [N];
  logic       fo [N];
  logic       il [N];
  logic       iso [N];
  logic       bc [N];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    tile_rule_engine #(.CAND_PER_CYCLE(cpc_of(g)), .STRICT(str_of(g))) u_dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (ir[g]),
      .up_tile    (up_tile),
      .down_tile  (down_tile),
      .left_tile  (left_tile),
      .right_tile (right_tile),
      .out_valid  (ov[g]),
      .out_ready  (out_ready),
      .tile_type  (tt[g]),
      .legal_count(lc[g]),
      .forced     (fo[g]),
      .illegal    (il[g]),
      .isolated   (iso[g]),
      .bad_code   (bc[g])
    );
  end

  typedef struct packed {
    logic [5:0] mask;
    logic [2:0] cnt;
    logic       forced;
    logic       illegal;
    logic       isolated;
    logic       bad;
  } res_t;

  typedef struct packed {
    res_t s;   // expectation for STRICT=1 instances
    res_t n;   // expectation for STRICT=0 instance
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic res_t mk(input logic [5:0] m, input logic [2:0] c, input logic f,
                              input logic ill, input logic is, input logic b);
    return {m, c, f, ill, is, b};
  endfunction

  function automatic res_t observed(input int i);
    return {tt[i], lc[i], fo[i], il[i], iso[i], bc[i]};
  endfunction

  function automatic bit all_ready();
    for (int i = 0; i < N; i++) if (ir[i] !== 1'b1) return 1'b0;
    return 1'b1;
  endfunction

  // side: 0=L 1=U 2=R 3=D
  function automatic bit white(input logic [2:0] code, input int side);
    case (code)
      3'd1:    return side == 0 || side == 1;
      3'd2:    return side == 2 || side == 3;
      3'd3:    return side == 1 || side == 2;
      3'd4:    return side == 0 || side == 3;
      3'd5:    return side == 0 || side == 2;
      3'd6:    return side == 1 || side == 3;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] u, input logic [2:0] d,
                                 input logic [2:0] l, input logic [2:0] r);
    exp_t       e;
    logic [5:0] m;
    int         cnt;
    bit         ok, bad, isol;
    m   = '0;
    cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      ok = 1'b1;
      if (l != 0 && white(3'(c), 0) != white(l, 2)) ok = 1'b0;
      if (u != 0 && white(3'(c), 1) != white(u, 3)) ok = 1'b0;
      if (r != 0 && white(3'(c), 2) != white(r, 0)) ok = 1'b0;
      if (d != 0 && white(3'(c), 3) != white(d, 1)) ok = 1'b0;
      if (ok) begin
        m   = m | (6'b000001 << (c - 1));
        cnt = cnt + 1;
      end
    end
    bad  = (u == 7) || (d == 7) || (l == 7) || (r == 7);
    isol = (u == 0) && (d == 0) && (l == 0) && (r == 0);
    if (bad) begin
      e.s = mk(6'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      e.n = e.s;
    end else if (isol) begin
      e.s = mk(6'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      e.n = mk(6'b111111, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      e.s = mk(m, 3'(cnt), cnt == 1, cnt == 0, 1'b0, 1'b0);
      e.n = e.s;
    end
    return e;
  endfunction

  task automatic run_req(input logic [2:0] u, input logic [2:0] d, input logic [2:0] l,
                         input logic [2:0] r, input exp_t e, input string name, input int hold);
    int   lat [N];
    int   n;
    bit   done;
    bit   stable [N];
    res_t snap [N];
    exp_t got;
    res_t want;
    exp_q.push_back(e);
    @(negedge clock);
    n = 0;
    while (!all_ready() && n < 50) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (n >= 50) begin
      n_bad++;
      $display("FAIL %s idle_wait: in_ready never rose within 50 cycles", name);
    end
    up_tile = u; down_tile = d; left_tile = l; right_tile = r;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    up_tile = 3'd3; down_tile = 3'd6; left_tile = 3'd2; right_tile = 3'd1;
    n_cmp++;
    if (ir[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_ready: in_ready=%b want 0", name, ir[0]);
    end
    for (int i = 0; i < N; i++) lat[i] = -1;
    n = 0;
    forever begin
      done = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (ov[i] === 1'b1 && lat[i] < 0) lat[i] = n;
        if (lat[i] < 0) done = 1'b0;
      end
      if (done || n >= 20) break;
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    got = exp_q.pop_front();
    for (int i = 0; i < N; i++) begin
      want = str_of(i) ? got.s : got.n;
      n_cmp++;
      if (observed(i) !== want) begin
        n_bad++;
        $display("FAIL %s result dut%0d: got mask=%b cnt=%0d f/il/iso/bad=%b%b%b%b want mask=%b cnt=%0d f/il/iso/bad=%b%b%b%b",
                 name, i, tt[i], lc[i], fo[i], il[i], iso[i], bc[i],
                 want.mask, want.cnt, want.forced, want.illegal, want.isolated, want.bad);
      end
      n_cmp++;
      if (lat[i] != 6 / cpc_of(i)) begin
        n_bad++;
        $display("FAIL %s latency dut%0d: got %0d want %0d", name, i, lat[i], 6 / cpc_of(i));
      end
    end
    if (hold > 0) begin
      for (int i = 0; i < N; i++) begin
        snap[i]   = observed(i);
        stable[i] = 1'b1;
      end
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < N; i++)
          if (observed(i) !== snap[i] || ov[i] !== 1'b1 || ir[i] !== 1'b0) stable[i] = 1'b0;
      end
      in_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (!stable[i]) begin
          n_bad++;
          $display("FAIL %s backpressure dut%0d: got out_valid=%b in_ready=%b result=%h want 1 0 %h held",
                   name, i, ov[i], ir[i], observed(i), snap[i]);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL %s release dut%0d: got in_ready=%b out_valid=%b want 1 0", name, i, ir[i], ov[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (observed(i) !== '0 || ov[i] !== 1'b0 || ir[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: got result=%h out_valid=%b in_ready=%b want 0 0 0",
                 i, observed(i), ov[i], ir[i]);
      end
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (!all_ready()) begin
      n_bad++;
      $display("FAIL reset_release: in_ready dut0=%b want 1", ir[0]);
    end
  endtask

  task automatic test_single();
    run_req(3'd0, 3'd0, 3'd5, 3'd0, '{s: mk(6'b011001, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0),
                                     n: mk(6'b011001, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0)}, "single", 0);
  endtask

  task automatic test_forced();
    run_req(3'd2, 3'd0, 3'd5, 3'd0, '{s: mk(6'b000001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0),
                                     n: mk(6'b000001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0)}, "forced_a", 0);
    run_req(3'd1, 3'd0, 3'd5, 3'd5, '{s: mk(6'b010000, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0),
                                     n: mk(6'b010000, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0)}, "forced_b", 0);
  endtask

  task automatic test_reset_mid_eval();
    bit seen;
    @(negedge clock);
    up_tile = 3'd2; down_tile = 3'd0; left_tile = 3'd5; right_tile = 3'd0;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    n_cmp++;
    if (ov[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_eval_busy: out_valid=%b want 0", ov[0]);
    end
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (observed(i) !== '0 || ov[i] !== 1'b0 || ir[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_eval_reset dut%0d: got result=%h out_valid=%b in_ready=%b want 0 0 0",
                 i, observed(i), ov[i], ir[i]);
      end
    end
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (ov[0] !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen || ir[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_eval_abort: got stray out_valid=%b in_ready=%b want 0 1", seen, ir[0]);
    end
  endtask

  task automatic test_illegal();
    run_req(3'd2, 3'd0, 3'd5, 3'd5, '{s: mk(6'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0),
                                     n: mk(6'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)}, "illegal", 0);
  endtask

  task automatic test_isolated();
    run_req(3'd0, 3'd0, 3'd0, 3'd0, '{s: mk(6'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0),
                                     n: mk(6'b111111, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0)}, "isolated", 0);
  endtask

  task automatic test_bad_code_backpressure();
    run_req(3'd0, 3'd7, 3'd5, 3'd0, '{s: mk(6'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1),
                                     n: mk(6'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1)}, "bad_code", 10);
  endtask

  task automatic test_random();
    logic [2:0] c [4];
    for (int t = 0; t < 24; t++) begin
      for (int s = 0; s < 4; s++) begin
        if ($urandom_range(0, 3) == 0) c[s] = 3'd0;
        else if ($urandom_range(0, 15) == 0) c[s] = 3'd7;
        else c[s] = 3'($urandom_range(1, 6));
      end
      run_req(c[0], c[1], c[2], c[3], model(c[0], c[1], c[2], c[3]), "random", (t % 6 == 0) ? 3 : 0);
    end
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_forced();
    test_reset_mid_eval();
    test_illegal();
    test_isolated();
    test_bad_code_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
